// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset/lock sequencer owning sys_rst; define PLL_SUPERVISOR_RELOCK_EN to re-acquire on lock loss
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 32,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int MAX_RETRIES         = 3,
  localparam int RW = $clog2(MAX_RETRIES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pll_lock,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          ready,
  output logic          fail,
  output logic          lock_lost,
  output logic [RW-1:0] retry_count
);
  localparam int CMAX = RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FAIL  = 2'd3;
  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] stable, stable_nxt;
  logic [RW-1:0] retry_nxt;
  logic          lock_lost_nxt;
  logic          sync1, lock_s;
  // two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= pll_lock;
      lock_s <= sync1;
    end
  end
  // next-state: pulse, wait for debounced lock or timeout, run, or give up
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = '0;
    stable_nxt    = '0;
    retry_nxt     = retry_count;
    lock_lost_nxt = lock_lost;
    case (state)
      S_RESET: begin
        state_nxt = cnt == CW'(RST_PULSE_CYCLES - 1) ? S_WAIT : S_RESET;
        cnt_nxt   = cnt == CW'(RST_PULSE_CYCLES - 1) ? '0 : cnt + CW'(1);
      end
      S_WAIT: begin
        stable_nxt = lock_s ? stable + SW'(1) : '0;
        cnt_nxt    = cnt + CW'(1);
        if (lock_s && stable == SW'(LOCK_STABLE_CYCLES - 1))
          state_nxt = S_RUN;
        else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          cnt_nxt = '0;
          if (retry_count == RW'(MAX_RETRIES))
            state_nxt = S_FAIL;
          else begin
            retry_nxt = retry_count + RW'(1);
            state_nxt = S_RESET;
          end
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          lock_lost_nxt = 1'b1;
`ifdef PLL_SUPERVISOR_RELOCK_EN
          state_nxt = S_RESET;
          retry_nxt = '0;
`endif
        end
      end
      default: ;
    endcase
  end
  // state, counters and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RESET;
      cnt         <= '0;
      stable      <= '0;
      retry_count <= '0;
      lock_lost   <= 1'b0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      stable      <= stable_nxt;
      retry_count <= retry_nxt;
      lock_lost   <= lock_lost_nxt;
      pll_rst     <= state_nxt == S_RESET;
      sys_rst     <= state_nxt != S_RUN;
      ready       <= state_nxt == S_RUN;
      fail        <= state_nxt == S_FAIL;
    end
  end
endmodule
